// File: rtl/uart_rx_top.sv
// uart_rx_top - receive half of a 16550-style UART.
//
// Oversamples the serial line with a 16x enable from an external baud
// generator. Deserializes 5-8 data bits LSB first, optionally checks
// parity (odd/even/stick) and the stop bit, and detects a break. One
// push strobe per frame carries the byte and its error flags to the RX
// FIFO / line-status logic.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   baud_pulse    one-clk oversampling enable; all activity advances on it
//   rx            serial input, idle high
//   sticky_parity stick parity (expected parity bit = ~eps)
//   eps           even parity select (1 = even, 0 = odd)
//   pen           parity enable
//   wls           word length: 00=5, 01=6, 10=7, 11=8 bits
//   push          one-clk strobe: dout/pe/fe/bi updated for a new frame
//   pe, fe, bi    parity error, framing error, break of the last frame
//   dout          received data, right-justified, unused upper bits 0
//
// State      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | line idle, waiting for a low sample
// S_START    | possible start bit, re-checked at mid-bit
// S_DATA     | shifting in data bits at mid-bit
// S_PARITY   | sampling the parity bit
// S_STOP     | sampling the stop bit, publishing the frame

module uart_rx_top #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       pen,
  input  logic [1:0] wls,
  output logic       push,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic [7:0] dout
);

  localparam int CW = $clog2(OVERSAMPLE);
  // Terminal counts: the tick counter starts at 0 on entry to a state, so
  // the Nth tick in the state is the one that sees the count at N-1.
  localparam logic [CW-1:0] HALF_TC = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   tick_cnt, tick_cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift_reg, shift_nxt;
  logic            par_err, par_err_nxt;
  logic            par_bit, par_bit_nxt;
  logic            push_nxt, pe_nxt, fe_nxt, bi_nxt;
  logic [7:0]      dout_nxt;

  logic [2:0]      last_bit;
  logic            tc_half, tc_full;
  logic            par_exp;

  assign last_bit = 3'd4 + {1'b0, wls};
  assign tc_half  = (tick_cnt == HALF_TC);
  assign tc_full  = (tick_cnt == FULL_TC);

  // Unused upper bits of shift_reg stay 0, so the full-width reduction is
  // the parity of the received word. Even parity wants data^par == 0.
  always_comb begin
    par_exp = 1'b0;
    if (sticky_parity) par_exp = ~eps;
    else if (eps)      par_exp = ^shift_reg;
    else               par_exp = ~(^shift_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
      par_bit   <= 1'b0;
      push      <= 1'b0;
      pe        <= 1'b0;
      fe        <= 1'b0;
      bi        <= 1'b0;
      dout      <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      par_err   <= par_err_nxt;
      par_bit   <= par_bit_nxt;
      push      <= push_nxt;
      pe        <= pe_nxt;
      fe        <= fe_nxt;
      bi        <= bi_nxt;
      dout      <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    par_err_nxt  = par_err;
    par_bit_nxt  = par_bit;
    push_nxt     = 1'b0;
    pe_nxt       = pe;
    fe_nxt       = fe;
    bi_nxt       = bi;
    dout_nxt     = dout;

    if (baud_pulse) begin
      case (state)
        S_IDLE: begin
          if (!rx) begin
            state_nxt    = S_START;
            tick_cnt_nxt = '0;
          end
        end

        S_START: begin
          if (tc_half) begin
            tick_cnt_nxt = '0;
            if (!rx) begin
              state_nxt   = S_DATA;
              bit_cnt_nxt = '0;
              shift_nxt   = '0;
              par_err_nxt = 1'b0;
              par_bit_nxt = 1'b0;
            end else begin
              // Line went back high before mid-bit: treat as noise.
              state_nxt = S_IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (tc_full) begin
            tick_cnt_nxt       = '0;
            shift_nxt[bit_cnt] = rx;
            if (bit_cnt == last_bit) begin
              state_nxt = pen ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        S_PARITY: begin
          if (tc_full) begin
            tick_cnt_nxt = '0;
            par_bit_nxt  = rx;
            par_err_nxt  = (rx != par_exp);
            state_nxt    = S_STOP;
          end else begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        S_STOP: begin
          if (tc_full) begin
            tick_cnt_nxt = '0;
            push_nxt     = 1'b1;
            dout_nxt     = shift_reg;
            fe_nxt       = ~rx;
            pe_nxt       = pen & par_err;
            // Break: every sampled bit of the frame was low.
            bi_nxt       = (shift_reg == 8'h00) && (!pen || !par_bit) && !rx;
            state_nxt    = S_IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        default: begin
          state_nxt    = S_IDLE;
          tick_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
module tb_uart_rx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic       rx;
  logic       sticky_parity;
  logic       eps;
  logic       pen;
  logic [1:0] wls;
  logic       push;
  logic       pe;
  logic       fe;
  logic       bi;
  logic [7:0] dout;

  int n_cmp     = 0;
  int n_err     = 0;
  int push_cnt  = 0;
  int tick_no   = 0;
  int push_tick = 0;

  logic [7:0] cap_dout;
  logic       cap_pe, cap_fe, cap_bi;

  always #5 clk = ~clk;

  uart_rx_top #(.OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse   (baud_pulse),
    .rx           (rx),
    .sticky_parity(sticky_parity),
    .eps          (eps),
    .pen          (pen),
    .wls          (wls),
    .push         (push),
    .pe           (pe),
    .fe           (fe),
    .bi           (bi),
    .dout         (dout)
  );

  always @(posedge clk) begin
    #1;
    if (push === 1'b1) begin
      push_cnt++;
      push_tick = tick_no;
      cap_dout  = dout;
      cap_pe    = pe;
      cap_fe    = fe;
      cap_bi    = bi;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One oversampling tick every 6 clk.
  task automatic do_tick();
    @(negedge clk);
    baud_pulse = 1'b1;
    tick_no++;
    @(negedge clk);
    baud_pulse = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic hold_rx(input logic val, input int nticks);
    rx = val;
    repeat (nticks) do_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input bit par, input bit stop, output int n_push, output int lat);
    int p0, t0;
    p0 = push_cnt;
    t0 = tick_no + 1;
    hold_rx(1'b0, 16);
    for (int i = 0; i < nbits; i++) hold_rx(data[i], 16);
    if (has_par) hold_rx(par, 16);
    hold_rx(stop, 16);
    hold_rx(1'b1, 24);
    n_push = push_cnt - p0;
    lat    = push_tick - t0;
  endtask

  task automatic set_lcr(input logic [1:0] w, input logic p, input logic e, input logic s);
    wls = w; pen = p; eps = e; sticky_parity = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int np, lat, p0;
    rst = 1'b1; baud_pulse = 1'b0; rx = 1'b1;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_val("rst_push", push, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_flags", {pe, fe, bi}, 0);
    rst = 1'b0;
    hold_rx(1'b1, 20);
    check_val("idle_no_push", push_cnt, 0);

    // 8 bits, odd parity, parity bit 1 with three ones in 0x45 -> error
    set_lcr(2'b11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h45, 8, 1'b1, 1'b1, 1'b1, np, lat);
    check_val("odd_push_cnt", np, 1);
    check_val("odd_dout", cap_dout, 8'h45);
    check_val("odd_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b100);

    // Same frame, even parity -> good
    set_lcr(2'b11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h45, 8, 1'b1, 1'b1, 1'b1, np, lat);
    check_val("even_push_cnt", np, 1);
    check_val("even_dout", cap_dout, 8'h45);
    check_val("even_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b000);

    // 5 bits, no parity; latency 8 + 16*6 ticks
    set_lcr(2'b00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, np, lat);
    check_val("w5_push_cnt", np, 1);
    check_val("w5_dout", cap_dout, 8'h15);
    check_val("w5_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b000);
    check_val("w5_latency", lat, 104);

    // 6 bits, even parity, 0x2A has three ones -> parity bit 1 is correct
    set_lcr(2'b01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h2A, 6, 1'b1, 1'b1, 1'b1, np, lat);
    check_val("w6_dout", cap_dout, 8'h2A);
    check_val("w6_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b000);
    check_val("w6_latency", lat, 8 + 16 * 8);

    // 7 bits, stick parity with eps=0 expects a 1; send 0 -> error
    set_lcr(2'b10, 1'b1, 1'b0, 1'b1);
    send_frame(8'h7F, 7, 1'b1, 1'b0, 1'b1, np, lat);
    check_val("stick_dout", cap_dout, 8'h7F);
    check_val("stick_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b100);

    // Break: whole 8E1 frame low
    set_lcr(2'b11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, np, lat);
    check_val("brk_push_cnt", np, 1);
    check_val("brk_dout", cap_dout, 8'h00);
    check_val("brk_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b011);

    // Stop bit low with nonzero data: framing error, no break
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, np, lat);
    check_val("fe_push_cnt", np, 1);
    check_val("fe_dout", cap_dout, 8'hA5);
    check_val("fe_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b010);

    // Glitch shorter than half a bit is rejected
    p0 = push_cnt;
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 40);
    check_val("glitch_no_push", push_cnt - p0, 0);
    check_val("glitch_hold_dout", dout, 8'hA5);

    // Reset in the middle of the data bits aborts the frame
    p0 = push_cnt;
    hold_rx(1'b0, 16);
    hold_rx(1'b1, 16);
    hold_rx(1'b0, 16);
    hold_rx(1'b1, 16);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check_val("abort_dout", dout, 0);
    check_val("abort_flags", {pe, fe, bi}, 0);
    hold_rx(1'b1, 200);
    check_val("abort_no_push", push_cnt - p0, 0);

    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, np, lat);
    check_val("after_rst_push_cnt", np, 1);
    check_val("after_rst_dout", cap_dout, 8'h3C);
    check_val("after_rst_pe_fe_bi", {cap_pe, cap_fe, cap_bi}, 3'b000);
    check_val("after_rst_latency", lat, 8 + 16 * 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
